// File: rtl/mc_command_queue.sv
`default_nettype none
// ============================================================================
// Module   : mc_command_queue
// Purpose  : Circular command queue feeding the stepper controller, with
//            passthrough when empty and auto-dispatch of the next move.
//            Optional drain interrupt: define MC_QUEUE_DRAIN_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_command_queue #(
  parameter int DEPTH     = 64,
  parameter int CMD_WIDTH = 162,
  localparam int IW       = $clog2(DEPTH + 1)
) (
  input  logic                 Clk_ik,
  input  logic                 Rstn_i,
  input  logic [CMD_WIDTH-1:0] CommandIn_b,
  input  logic                 DoQueue_i,
  input  logic                 ResetQueue_i,
  input  logic                 StepperDone_i,
  output logic [CMD_WIDTH-1:0] CommandOut_b,
  output logic                 Dispatch_o,
  output logic                 QueueFull_o,
  output logic [IW-1:0]        QueueItems_o,
  output logic                 Overflow_o,
  output logic                 DrainIrq_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);

  logic [CMD_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] items_q, items_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          disp_q, disp_d;
  logic          pop_ok, push_ok, wr_en, drained;

  // A full queue still accepts a push when the head retires in the same cycle.
  assign pop_ok  = StepperDone_i && (items_q != '0);
  assign push_ok = DoQueue_i && ((items_q != DEPTH_C) || pop_ok);
  assign wr_en   = push_ok && !ResetQueue_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    items_d  = items_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    disp_d   = 1'b0;
    drained  = 1'b0;
    if (ResetQueue_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      items_d  = '0;
      full_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   items_d = items_q + IW'(1);
        2'b01:   items_d = items_q - IW'(1);
        default: items_d = items_q;
      endcase
      full_d = (items_d == DEPTH_C);
      if (DoQueue_i && !push_ok) ovf_d = 1'b1;
      disp_d  = pop_ok && (items_d != '0);
      drained = pop_ok && (items_d == '0);
    end
  end

  always_ff @(posedge Clk_ik) begin
    if (!Rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      items_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      items_q  <= items_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      disp_q   <= disp_d;
    end
  end

  // Entries are not reset; the passthrough mux hides stale contents.
  always_ff @(posedge Clk_ik) begin
    if (Rstn_i && wr_en) mem[wr_ptr_q] <= CommandIn_b;
  end

  assign CommandOut_b = (items_q == '0) ? CommandIn_b : mem[rd_ptr_q];
  assign Dispatch_o   = disp_q && !ResetQueue_i;
  assign QueueFull_o  = full_q;
  assign QueueItems_o = items_q;
  assign Overflow_o   = ovf_q;

`ifdef MC_QUEUE_DRAIN_IRQ_EN
  logic drain_q;

  always_ff @(posedge Clk_ik) begin
    if (!Rstn_i) drain_q <= 1'b0;
    else         drain_q <= drained;
  end

  assign DrainIrq_o = drain_q;
`else
  assign DrainIrq_o = 1'b0;
  logic unused_drained;
  assign unused_drained = drained;
`endif

endmodule
`default_nettype wire
